// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, Jump field
// encodings and the next-pc source selector used between FSM and target calc.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_HALT     = 2'd3
  } fs_state_t;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REG = 2'b10;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_SEQ    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_ABS    = 3'd3,
    PC_REG    = 3'd4,
    PC_RET    = 3'd5
  } pc_sel_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_target_calc.sv
// Combinational next-address selection for the fetch sequencer; all targets
// are truncated to ADDR_W so every path wraps modulo 2^ADDR_W.
module pc_target_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [2:0]        i_sel,
  input  logic [15:0]       i_imm_offset,
  input  logic [25:0]       i_jump_target,
  input  logic [31:0]       i_reg_target,
  input  logic [ADDR_W-1:0] i_ret_addr,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic [ADDR_W-1:0] o_pc_plus1
);

  logic [31:0] w_branch_sum;
  logic        w_unused;

  assign o_pc_plus1 = i_pc + ADDR_W'(1);

  // Offset is added at 32 bits and truncated, giving wrap in both directions.
  assign w_branch_sum = 32'(i_pc) + 32'd1 + sext16(i_imm_offset);

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_HOLD:   o_next_pc = i_pc;
      PC_SEQ:    o_next_pc = o_pc_plus1;
      PC_BRANCH: o_next_pc = w_branch_sum[ADDR_W-1:0];
      PC_ABS:    o_next_pc = i_jump_target[ADDR_W-1:0];
      PC_REG:    o_next_pc = i_reg_target[ADDR_W-1:0];
      PC_RET:    o_next_pc = i_ret_addr;
      default:   o_next_pc = i_pc;
    endcase
  end

  assign w_unused = ^{w_branch_sum[31:ADDR_W], i_jump_target[25:ADDR_W],
                      i_reg_target[31:ADDR_W]};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns pc, the user-process return register and
// the RUN / WAIT_IN / WAIT_REL / HALT control FSM.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned OS_ENTRY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        Jump,
  input  logic              Branch,
  input  logic              alu_zero,
  input  logic              halt,
  input  logic              input_flag,
  input  logic              changeROM,
  input  logic              EndOfProcess,
  input  logic              input_ready,
  input  logic [15:0]       imm_offset,
  input  logic [25:0]       jump_target,
  input  logic [31:0]       reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              stall,
  output logic              in_commit,
  output logic              halted,
  output logic              inProgram
);

  fs_state_t         r_state;
  fs_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ret;
  logic [ADDR_W-1:0] w_ret_nxt;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic              r_inprog;
  logic              w_inprog_nxt;
  logic              w_stall;
  logic              w_commit;
  pc_sel_t           w_sel;

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_pc_target_calc (
    .i_pc          (r_pc),
    .i_sel         (w_sel),
    .i_imm_offset  (imm_offset),
    .i_jump_target (jump_target),
    .i_reg_target  (reg_target),
    .i_ret_addr    (r_ret),
    .o_next_pc     (w_next_pc),
    .o_pc_plus1    (w_pc_plus1)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_pc     <= ADDR_W'(OS_ENTRY);
      r_ret    <= '0;
      r_inprog <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_next_pc;
      r_ret    <= w_ret_nxt;
      r_inprog <= w_inprog_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel        = PC_HOLD;
    w_ret_nxt    = r_ret;
    w_inprog_nxt = r_inprog;
    w_stall      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_state_nxt = ST_HALT;
        end else if (EndOfProcess) begin
          if (r_inprog) begin
            w_sel        = PC_RET;
            w_inprog_nxt = 1'b0;
          end else begin
            w_sel = PC_SEQ;
          end
        end else if (changeROM) begin
          // No nesting: a second changeROM inside a user process is a no-op.
          if (!r_inprog) begin
            w_sel        = PC_REG;
            w_ret_nxt    = w_pc_plus1;
            w_inprog_nxt = 1'b1;
          end else begin
            w_sel = PC_SEQ;
          end
        end else if (input_flag) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_WAIT_IN;
        end else if (Branch && alu_zero) begin
          w_sel = PC_BRANCH;
        end else begin
          case (Jump)
            JMP_ABS: w_sel = PC_ABS;
            JMP_REG: w_sel = PC_REG;
            default: w_sel = PC_SEQ;
          endcase
        end
      end
      ST_WAIT_IN: begin
        if (input_ready) begin
          w_commit    = 1'b1;
          w_sel       = PC_SEQ;
          w_state_nxt = ST_WAIT_REL;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        // Held until the confirm level drops so one press commits one input.
        w_stall = 1'b1;
        if (!input_ready) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Strobes are gated by reset so they drop the instant reset asserts.
  assign stall     = w_stall && reset;
  assign in_commit = w_commit && reset;
  assign pc        = r_pc;
  assign pc_plus1  = w_pc_plus1;
  assign halted    = (r_state == ST_HALT);
  assign inProgram = r_inprog;

endmodule
